// File: rtl/sif_xa_initiator.sv
// SIF xa bus initiator: queued write/read commands issued as single-cycle
// strobes, read data captured after a fixed latency onto a response port.
module sif_xa_initiator #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int CMD_DEPTH = 4,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] xa_addr,
  output logic [DATA_W-1:0] xa_data_wr,
  output logic              xa_wr_s,
  output logic              xa_rd_s,
  input  logic [DATA_W-1:0] xa_data_rd,
  output logic              busy
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam logic [PW:0] FULL = (PW+1)'(CMD_DEPTH);
  localparam logic [2:0] LAT = 3'(RD_LAT);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic [EW-1:0] mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic empty, push, pop, cap, rd_ok;
  logic head_wr;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign cmd_ready = (count != FULL);
  assign empty = (count == '0);
  assign push = cmd_valid && cmd_ready;
  assign {head_wr, head_addr, head_data} = mem[rd_ptr];
  assign cap = (state == RD_WAIT) && (cnt == LAT);
  assign busy = !empty || (state != IDLE) || rsp_valid;

  // The capture cycle doubles as an issue slot; a read issued
  // there needs the consumer to be taking the response now.
  assign rd_ok = (state == IDLE) ? (!rsp_valid || rsp_ready)
                                 : rsp_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pop      = 1'b0;
    if (state == RD_WAIT) begin
      cnt_nx = cnt + 3'd1;
      if (cap) state_nx = IDLE;
    end
    if ((state == IDLE || cap) && !empty) begin
      if (head_wr) begin
        pop = 1'b1;
      end else if (rd_ok) begin
        pop      = 1'b1;
        state_nx = RD_WAIT;
        cnt_nx   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_wr, cmd_addr, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      xa_wr_s    <= 1'b0;
      xa_rd_s    <= 1'b0;
      xa_addr    <= '0;
      xa_data_wr <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count   <= count + (PW+1)'(push) - (PW+1)'(pop);
      xa_wr_s <= pop && head_wr;
      xa_rd_s <= pop && !head_wr;
      if (pop) begin
        xa_addr <= head_addr;
        if (head_wr) xa_data_wr <= head_data;
      end
      if (cap) begin
        rsp_valid <= 1'b1;
        rsp_data  <= xa_data_rd;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sif_xa_initiator.sv
// Bench for sif_xa_initiator: directed steps plus a randomized run
// scored against a transaction-level model of the command stream.
module tb_sif_xa_initiator;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
  } cmd_t;

  logic clk, rst;
  logic cmd_valid, cmd_ready, cmd_wr;
  logic [15:0] cmd_addr, cmd_data;
  logic rsp_valid, rsp_ready;
  logic [15:0] rsp_data, xa_addr, xa_data_wr, xa_data_rd;
  logic xa_wr_s, xa_rd_s, busy;

  logic c3_valid, c3_ready, c3_wr;
  logic [15:0] c3_addr, c3_data;
  logic r3_valid, r3_ready;
  logic [15:0] r3_data, x3_addr, x3_dwr, x3_drd;
  logic x3_wr_s, x3_rd_s, busy3;

  int checks = 0;
  int failures = 0;

  sif_xa_initiator #(.RD_LAT(LAT1)) u1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .xa_addr(xa_addr), .xa_data_wr(xa_data_wr),
    .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
    .xa_data_rd(xa_data_rd), .busy(busy)
  );

  sif_xa_initiator #(.RD_LAT(LAT3)) u3 (
    .clk(clk), .rst(rst),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_wr(c3_wr),
    .cmd_addr(c3_addr), .cmd_data(c3_data),
    .rsp_valid(r3_valid), .rsp_ready(r3_ready), .rsp_data(r3_data),
    .xa_addr(x3_addr), .xa_data_wr(x3_dwr),
    .xa_wr_s(x3_wr_s), .xa_rd_s(x3_rd_s),
    .xa_data_rd(x3_drd), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [15:0] a,
                      input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_data  = d;
    tick;
    cmd_valid = 1'b0;
  endtask

  initial begin
    bit found;
    int k, bad, rd_c, wr_c, ns, nr;
    int s[2];
    int rc[2];
    logic [15:0] rv[2];
    int mcount, cap_at;
    bit rd_out, m_rv;
    logic [15:0] m_rd, last_wd;
    cmd_t q[$];
    cmd_t e;

    rst = 1'b1;
    cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_data = 0;
    rsp_ready = 0; xa_data_rd = 0;
    c3_valid = 0; c3_wr = 0; c3_addr = 0; c3_data = 0;
    r3_ready = 0; x3_drd = 0;
    tick;
    tick;
    rst = 1'b0;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_xa_addr", 32'(xa_addr), 32'd0);
    chk("reset_xa_data_wr", 32'(xa_data_wr), 32'd0);
    chk("reset_strobes", 32'({xa_wr_s, xa_rd_s}), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // reset while a read is outstanding and a write is queued
    push(1'b0, 16'h0077, 16'h0000);
    push(1'b1, 16'h0078, 16'h5555);
    found = 0;
    for (int i = 0; i < 6; i++) begin
      if (xa_rd_s) begin found = 1; break; end
      tick;
    end
    chk("midrst_rd_seen", 32'(found), 32'd1);
    chk("midrst_rd_addr", 32'(xa_addr), 32'h77);
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rd_s", 32'(xa_rd_s), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(xa_addr), 32'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (xa_wr_s || xa_rd_s) bad++;
    end
    chk("midrst_no_strobe", 32'(bad), 32'd0);

    // four back-to-back writes
    k = 0;
    for (int n = 0; n < 8; n++) begin
      cmd_valid = (n < 4);
      cmd_wr    = 1'b1;
      cmd_addr  = 16'(32'h10 + n);
      cmd_data  = 16'(32'hA000 + n);
      if (xa_wr_s) begin
        chk($sformatf("wr%0d_addr", k), 32'(xa_addr), 32'h10 + 32'(k));
        chk($sformatf("wr%0d_data", k), 32'(xa_data_wr),
            32'hA000 + 32'(k));
        chk($sformatf("wr%0d_cycle", k), 32'(n), 32'(k + 2));
        k++;
      end
      chk("wr_no_rd", 32'(xa_rd_s), 32'd0);
      tick;
    end
    cmd_valid = 1'b0;
    chk("wr_count", 32'(k), 32'd4);

    // single read with latency 1
    xa_data_rd = 16'h1111;
    push(1'b0, 16'h0040, 16'h0000);
    found = 0;
    for (int i = 0; i < 6; i++) begin
      if (xa_rd_s) begin found = 1; break; end
      tick;
    end
    chk("rd_seen", 32'(found), 32'd1);
    chk("rd_addr", 32'(xa_addr), 32'h40);
    chk("rd_hold_wdata", 32'(xa_data_wr), 32'hA003);
    chk("rd_no_wr", 32'(xa_wr_s), 32'd0);
    tick;
    chk("rd_rsp_early", 32'(rsp_valid), 32'd0);
    xa_data_rd = 16'hBEEF;
    tick;
    xa_data_rd = 16'h2222;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_data", 32'(rsp_data), 32'hBEEF);
    repeat (3) tick;
    chk("rd_hold_valid", 32'(rsp_valid), 32'd1);
    chk("rd_hold_data", 32'(rsp_data), 32'hBEEF);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("rd_consumed", 32'(rsp_valid), 32'd0);
    chk("rd_idle_busy", 32'(busy), 32'd0);

    // fill the FIFO behind a held response
    xa_data_rd = 16'h5050;
    push(1'b0, 16'h0050, 16'h0000);
    found = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) begin found = 1; break; end
      tick;
    end
    chk("full_held_rsp", 32'(found), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_wr    = (i != 0);
      cmd_addr  = 16'(32'h60 + i);
      cmd_data  = 16'(32'hC000 + i);
      chk($sformatf("full_ready_%0d", i), 32'(cmd_ready),
          32'(i < 4));
      tick;
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("full_stall", 32'({xa_wr_s, xa_rd_s}), 32'd0);
      chk("full_not_ready", 32'(cmd_ready), 32'd0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    xa_data_rd = 16'h6060;
    chk("full_ready_back", 32'(cmd_ready), 32'd1);
    chk("full_rd_s", 32'(xa_rd_s), 32'd1);
    chk("full_rd_addr", 32'(xa_addr), 32'h60);
    k = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (xa_wr_s) begin
        chk($sformatf("full_wr%0d_addr", k), 32'(xa_addr),
            32'h61 + 32'(k));
        chk($sformatf("full_wr%0d_data", k), 32'(xa_data_wr),
            32'hC001 + 32'(k));
        k++;
      end
      if (xa_rd_s) bad++;
    end
    chk("full_wr_count", 32'(k), 32'd3);
    chk("full_no_rd", 32'(bad), 32'd0);
    chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("full_rsp_data", 32'(rsp_data), 32'h6060);

    // ordering behind the still-held response
    push(1'b0, 16'h0001, 16'h0000);
    push(1'b1, 16'h0002, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      chk("ord_stall", 32'({xa_wr_s, xa_rd_s}), 32'd0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    rd_c = -1;
    wr_c = -1;
    for (int i = 0; i < 8; i++) begin
      if (xa_rd_s && rd_c < 0) begin
        rd_c = i;
        chk("ord_rd_addr", 32'(xa_addr), 32'h1);
      end
      if (xa_wr_s && wr_c < 0) begin
        wr_c = i;
        chk("ord_wr_addr", 32'(xa_addr), 32'h2);
        chk("ord_wr_data", 32'(xa_data_wr), 32'h1234);
      end
      tick;
    end
    chk("ord_rd_seen", 32'(rd_c >= 0), 32'd1);
    chk("ord_wr_seen", 32'(wr_c >= 0), 32'd1);
    chk("ord_rd_first", 32'(rd_c < wr_c), 32'd1);
    chk("ord_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("ord_rsp_taken", 32'(rsp_valid), 32'd0);

    // randomized traffic against a transaction-level model
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mcount = 0; cap_at = 0; rd_out = 0; m_rv = 0;
    m_rd = '0; last_wd = '0;
    for (int n = 0; n < 400; n++) begin
      if (xa_wr_s || xa_rd_s) begin
        chk("rand_one_strobe", 32'(xa_wr_s & xa_rd_s), 32'd0);
        chk("rand_q_has_cmd", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          mcount--;
          chk("rand_kind", 32'(xa_wr_s), 32'(e.wr));
          chk("rand_addr", 32'(xa_addr), 32'(e.a));
          if (e.wr) begin
            chk("rand_wdata", 32'(xa_data_wr), 32'(e.d));
            last_wd = e.d;
          end else begin
            chk("rand_wdata_hold", 32'(xa_data_wr), 32'(last_wd));
            rd_out = 1;
            cap_at = n + LAT1;
          end
        end
      end
      chk("rand_cmd_ready", 32'(cmd_ready), 32'(mcount != 4));
      chk("rand_rsp_valid", 32'(rsp_valid), 32'(m_rv));
      if (m_rv) chk("rand_rsp_data", 32'(rsp_data), 32'(m_rd));
      chk("rand_busy", 32'(busy), 32'(mcount != 0 || rd_out || m_rv));
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd_wr     = 1'($urandom_range(0, 1));
      cmd_addr   = 16'($urandom);
      cmd_data   = 16'($urandom);
      xa_data_rd = 16'($urandom);
      rsp_ready  = rd_out ? 1'b1 : 1'($urandom_range(0, 1));
      if (cmd_valid && mcount != 4) begin
        q.push_back('{cmd_wr, cmd_addr, cmd_data});
        mcount++;
      end
      if (m_rv && rsp_ready) m_rv = 0;
      if (rd_out && n == cap_at) begin
        m_rv = 1;
        m_rd = xa_data_rd;
        rd_out = 0;
      end
      tick;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;

    // latency-3 instance: two queued reads
    ns = 0;
    nr = 0;
    s = '{0, 0};
    rc = '{0, 0};
    rv = '{16'h0, 16'h0};
    r3_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      x3_drd   = 16'(32'h3000 + n);
      c3_valid = (n < 2);
      c3_wr    = 1'b0;
      c3_addr  = 16'(32'h100 + n);
      if (x3_rd_s && ns < 2) begin
        s[ns] = n;
        chk($sformatf("lat3_rd%0d_addr", ns), 32'(x3_addr),
            32'h100 + 32'(ns));
        ns++;
      end
      if (r3_valid && nr < 2) begin
        rc[nr] = n;
        rv[nr] = r3_data;
        nr++;
      end
      tick;
    end
    c3_valid = 1'b0;
    chk("lat3_rd_count", 32'(ns), 32'd2);
    chk("lat3_rsp_count", 32'(nr), 32'd2);
    chk("lat3_first_strobe", 32'(s[0]), 32'd2);
    chk("lat3_spacing", 32'(s[1] - s[0]), 32'd4);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("lat3_rsp%0d_data", j), 32'(rv[j]),
          32'(32'h3000 + s[j] + LAT3));
      chk($sformatf("lat3_rsp%0d_cycle", j), 32'(rc[j]),
          32'(s[j] + LAT3 + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sif_xa_initiator.md
Name: sif_xa_initiator

Overview:
Bus-initiator for the SIF xa port. It accepts write and read commands from a local command interface and queues them in a small FIFO. It issues them in order as single-cycle xa_wr_s / xa_rd_s strobes, captures xa_data_rd after a fixed read latency and returns read data on a valid/ready response port. It sits in front of the SIF block's xa side, in place of the testbench driver.

Parameters:
ADDR_W, 16, xa address width
DATA_W, 16, xa data width
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RD_LAT, 1, cycles from xa_rd_s strobe to xa_data_rd valid (1..7)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept a command (= not full)
cmd_wr  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  command address
cmd_data  input  DATA_W  write data (ignored for reads)
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer takes response
rsp_data  output  DATA_W  captured read data
xa_addr  output  ADDR_W  bus address
xa_data_wr  output  DATA_W  bus write data
xa_wr_s  output  1  write strobe, one-cycle pulse
xa_rd_s  output  1  read strobe, one-cycle pulse
xa_data_rd  input  DATA_W  bus read data
busy  output  1  FIFO non-empty or FSM not IDLE or rsp_valid

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst, applied on the posedge clk where rst=1.
- Reset values:
  - cmd_ready=1; rsp_valid=0; rsp_data=0.
  - xa_addr=0, xa_data_wr=0, xa_wr_s=0, xa_rd_s=0.
  - busy=0; FIFO empty; FSM=IDLE.
- Reset mid-operation:
  - Discards queued commands, any pending read and any held response.
  - Outstanding strobes drop in the next cycle.
- Command FIFO:
  - Push when cmd_valid&&cmd_ready.
  - cmd_ready = !full. It is a registered count compare with no pass-through, so cmd_ready stays 0 while full even if a pop happens in the same cycle.
  - Pointers wrap modulo CMD_DEPTH.
  - A simultaneous push and pop when neither empty nor full leaves the count unchanged.
- FSM states: IDLE, RD_WAIT.
- IDLE with FIFO non-empty, head is a write:
  - Pop the head and drive xa_addr/xa_data_wr from it in the next cycle, with xa_wr_s=1 for exactly that cycle.
  - Stay in IDLE, so back-to-back writes issue one per cycle.
- IDLE with FIFO non-empty, head is a read, rsp_valid=0 (or rsp_valid&&rsp_ready this cycle):
  - Pop the head and drive xa_addr with xa_rd_s=1 for one cycle.
  - xa_data_wr holds its previous value.
  - Go to RD_WAIT with a latency counter cleared.
- IDLE with a read at the head while the response is still held: stall. The read is not issued and following writes are not reordered past it.
- RD_WAIT:
  - The counter increments each cycle.
  - On the cycle RD_LAT cycles after the strobe cycle, sample xa_data_rd into rsp_data, set rsp_valid=1 and return to IDLE.
  - No strobe is issued while in RD_WAIT.
- Response handshake:
  - rsp_valid stays 1 and rsp_data stays stable until rsp_valid&&rsp_ready.
  - A new capture in the same cycle as a consume is legal (rsp_valid remains 1, data updates).
- xa_addr/xa_data_wr hold their last issued values between strobes.
- xa_wr_s and xa_rd_s are never both 1.
- Minimum read-to-read spacing is RD_LAT+1 cycles.
- Latency:
  - Command push to strobe is 2 cycles when the FIFO is empty and the FSM is IDLE (push cycle, then strobe the following cycle).
  - Read strobe to rsp_valid is RD_LAT+1 cycles.

Test Plan:
- Reset: hold rst 2 cycles mid-read (RD_WAIT) -> next cycle rsp_valid=0, xa_rd_s=0, cmd_ready=1, busy=0, xa_addr=0.
- Four writes pushed back-to-back (addr 0x0010..0x0013, data 0xA000..0xA003) -> four consecutive xa_wr_s pulses with matching addr/data in order, xa_rd_s=0 throughout.
- Read addr 0x0040, RD_LAT=1, bench drives xa_data_rd=0xBEEF one cycle after xa_rd_s -> rsp_valid=1, rsp_data=0xBEEF, held until rsp_ready.
- FIFO full: push 5 commands with the bus stalled behind a held response -> cmd_ready=0 after the 4th, 5th not accepted; after rsp_ready, cmd_ready returns to 1.
- Order: read 0x0001, then write 0x0002/0x1234, with rsp_ready=0 and a prior response held -> neither strobe issues until the response is consumed; then xa_rd_s precedes xa_wr_s.
- RD_LAT=3: two reads queued -> xa_rd_s pulses exactly 4 cycles apart, each rsp_data equals xa_data_rd sampled 3 cycles after its strobe.
